wb_ddr3_responder_model: RTL and testbench
==========================================

Name: wb_ddr3_responder_model

Overview:
- Behavioural Wishbone responder that stands in for the DDR3 controller's user port (pipelined Wishbone, stall/ack, aux echo).
- Lets UART/demo front-ends be brought up, simulated and tested on hardware without the DDR3 PHY.
- Contains on-chip RAM, fixed in-order response latency, an outstanding-request limit, an emulated calibration window and optional periodic stall injection.

Parameters:
- ADDR_BITS, 8: Wishbone address width. RAM depth is 2**ADDR_BITS words.
- DATA_BITS, 8: Wishbone data width. Must be a multiple of 8.
- AUX_WIDTH, 4: aux sideband width. Echoed on o_aux with each ack.
- RESP_LATENCY, 6: cycles from accepted request to its ack. Legal range is 1..16.
- MAX_OUTSTANDING, 4: maximum requests accepted but not yet acked. Legal range is 1..RESP_LATENCY.
- CAL_CYCLES, 64: stall cycles after reset before o_cal_done rises.
- STALL_PERIOD, 0: 0 disables stall injection. Otherwise o_wb_stall is forced high for 1 cycle in every STALL_PERIOD cycles.

Ports:
- i_controller_clk, in, 1: clock.
- i_rst, in, 1: synchronous, active-low reset.
- i_wb_cyc, in, 1: bus cycle. Low cancels all outstanding requests.
- i_wb_stb, in, 1: request strobe.
- i_wb_we, in, 1: 1 = write, 0 = read.
- i_wb_addr, in, ADDR_BITS: word address.
- i_wb_data, in, DATA_BITS: write data.
- i_wb_sel, in, DATA_BITS/8: byte enables for writes.
- i_aux, in, AUX_WIDTH: sideband tag, returned with the ack.
- o_wb_stall, out, 1: request not accepted this cycle.
- o_wb_ack, out, 1: one-cycle completion pulse.
- o_wb_data, out, DATA_BITS: read data. Zero on write acks.
- o_aux, out, AUX_WIDTH: aux of the request being acked.
- o_cal_done, out, 1: calibration window finished.
- o_outstanding, out, 5: current outstanding count (debug).

Behaviour:
- Reset (i_rst=0 at a clock edge):
  - o_wb_ack=0, o_wb_data=0, o_aux=0, o_cal_done=0, o_outstanding=0.
  - Delay line emptied; calibration and stall-injection counters cleared.
  - RAM contents preserved.
- Calibration:
  - Counter runs from reset release; o_cal_done rises after exactly CAL_CYCLES cycles and stays high until the next reset.
- Stall:
  - o_wb_stall = !o_cal_done | (o_outstanding == MAX_OUTSTANDING) | inject.
  - It is combinational from registered state only; no path from the input bus.
- Accept:
  - A request is accepted when i_wb_cyc & i_wb_stb & !o_wb_stall.
  - A stb while stalled is ignored; the master must hold it.
- Write on accept:
  - RAM[addr] is updated in the accept cycle for every byte whose i_wb_sel bit is 1.
- Read on accept:
  - RAM[addr] is sampled in the accept cycle, so a later write to the same address does not alter this response.
  - A read accepted in the cycle after a write to the same address returns the new data.
- Response:
  - The entry {valid, we, rdata, aux} enters a RESP_LATENCY-deep delay line.
  - o_wb_ack pulses exactly RESP_LATENCY cycles after accept, together with o_wb_data and o_aux. Acks are strictly in order.
  - With back-to-back accepts, acks are back-to-back.
- Outstanding count:
  - Increments on accept, decrements on ack.
  - Accept and ack in the same cycle leave the count unchanged.
  - The count never exceeds MAX_OUTSTANDING.
- Cancellation (i_wb_cyc=0):
  - At the next edge, all delay-line valid bits clear and o_outstanding becomes 0.
  - No ack is issued for cancelled requests; writes already applied are kept.
  - No request is accepted while cyc=0.
- Stall injection:
  - A free-running counter modulo STALL_PERIOD asserts inject when it equals STALL_PERIOD-1.
  - The counter runs only after o_cal_done.
- Reset mid-operation: in-flight requests are dropped with no ack.

Decomposition:
- Shared package wb_model_pkg holds:
  - localparam limits: RESP_LATENCY_MAX = 16, OUTSTANDING_W = 5.
  - The response-entry struct {valid, we, data, aux}.
- Sub-module wb_resp_delay_line:
  - Parameterised shift register of entries with a synchronous flush input; outputs the head entry.
- The top level owns the RAM, the counters and the stall logic.

Test Plan:
- Reset, then idle: o_wb_stall=1 and o_cal_done=0 for 64 cycles, then o_cal_done=1 and o_wb_stall=0 on cycle 64.
- Write addr 0x9E data 0x61 sel 1, then read 0x9E with aux 0x0: write ack at +6 with aux 0x1; read ack at +6 after its accept with data 0x61.
- 6 back-to-back reads with MAX_OUTSTANDING=4: exactly 4 accepted, stall high until the first ack, remaining accepts resume; 6 in-order acks.
- Read 0x10 (RAM holds 0x33) immediately followed by write 0x10 = 0x44: read ack returns 0x33; a subsequent read returns 0x44.
- 3 requests in flight, then cyc=0 for 1 cycle: no acks follow; o_outstanding=0; the write issued before the drop persists on readback.
- STALL_PERIOD=5 with stb held continuously: stall high 1 cycle in every 5, giving exactly 4 accepts per 5 cycles over 50 cycles (40 acks).

Source files
------------

// File: rtl/wb_model_pkg.sv
// Shared limits and the response-entry layout for the Wishbone DDR3 stand-in.
// Entry fields are sized for the widest supported bus; unused upper bits stay zero.
package wb_model_pkg;
    localparam int RESP_LATENCY_MAX = 16;
    localparam int OUTSTANDING_W    = 5;
    localparam int RESP_DATA_MAX    = 64;
    localparam int RESP_AUX_MAX     = 16;

    typedef struct packed {
        logic                     valid;
        logic                     we;
        logic [RESP_DATA_MAX-1:0] data;
        logic [RESP_AUX_MAX-1:0]  aux;
    } resp_entry_t;

    localparam int RESP_ENTRY_W = $bits(resp_entry_t);
endpackage

// File: rtl/wb_resp_delay_line.sv
// Fixed-depth response pipe: entry in, head out DEPTH cycles later; no backpressure.
// Flush and reset both empty every stage in one edge.
module wb_resp_delay_line
    import wb_model_pkg::*;
#(
    parameter int DEPTH = 6
) (
    input  logic                    i_controller_clk,
    input  logic                    i_rst,
    input  logic                    i_flush,
    input  logic [RESP_ENTRY_W-1:0] i_entry,
    output logic [RESP_ENTRY_W-1:0] o_head
);
    resp_entry_t r_stage [DEPTH];

    always_ff @(posedge i_controller_clk) begin
        if (!i_rst || i_flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_stage[i] <= '0;
            end
        end else begin
            r_stage[0] <= resp_entry_t'(i_entry);
            for (int i = 1; i < DEPTH; i++) begin
                r_stage[i] <= r_stage[i-1];
            end
        end
    end

    assign o_head = r_stage[DEPTH-1];
endmodule

// File: rtl/wb_ddr3_responder_model.sv
// Pipelined Wishbone responder with on-chip RAM; every ack lands RESP_LATENCY cycles after accept, in order.
// Stalls during calibration, at the outstanding limit, and on periodic injection; stall depends on registered state only.
module wb_ddr3_responder_model
    import wb_model_pkg::*;
#(
    parameter int ADDR_BITS       = 8,
    parameter int DATA_BITS       = 8,
    parameter int AUX_WIDTH       = 4,
    parameter int RESP_LATENCY    = 6,
    parameter int MAX_OUTSTANDING = 4,
    parameter int CAL_CYCLES      = 64,
    parameter int STALL_PERIOD    = 0
) (
    input  logic                     i_controller_clk,
    input  logic                     i_rst,
    input  logic                     i_wb_cyc,
    input  logic                     i_wb_stb,
    input  logic                     i_wb_we,
    input  logic [ADDR_BITS-1:0]     i_wb_addr,
    input  logic [DATA_BITS-1:0]     i_wb_data,
    input  logic [DATA_BITS/8-1:0]   i_wb_sel,
    input  logic [AUX_WIDTH-1:0]     i_aux,
    output logic                     o_wb_stall,
    output logic                     o_wb_ack,
    output logic [DATA_BITS-1:0]     o_wb_data,
    output logic [AUX_WIDTH-1:0]     o_aux,
    output logic                     o_cal_done,
    output logic [OUTSTANDING_W-1:0] o_outstanding
);
    localparam int SEL_BITS = DATA_BITS / 8;
    localparam int CAL_W    = $clog2(CAL_CYCLES + 1);
    localparam int INJ_W    = (STALL_PERIOD > 2) ? $clog2(STALL_PERIOD) : 1;

    if (RESP_LATENCY < 1 || RESP_LATENCY > RESP_LATENCY_MAX ||
        MAX_OUTSTANDING < 1 || MAX_OUTSTANDING > RESP_LATENCY ||
        DATA_BITS % 8 != 0 || DATA_BITS > RESP_DATA_MAX ||
        AUX_WIDTH > RESP_AUX_MAX || CAL_CYCLES < 1) begin : g_bad_params
        $error("wb_ddr3_responder_model: illegal parameter combination");
    end

    logic [DATA_BITS-1:0]     r_mem [0:(1<<ADDR_BITS)-1];
    logic [CAL_W-1:0]         r_cal_cnt;
    logic                     r_cal_done;
    logic [INJ_W-1:0]         r_inj_cnt;
    logic [OUTSTANDING_W-1:0] r_outstanding;

    logic                     w_inject;
    logic                     w_stall;
    logic                     w_accept;
    logic                     w_ack;
    logic [DATA_BITS-1:0]     w_rdata;
    resp_entry_t              w_in_entry;
    resp_entry_t              w_head_entry;
    logic                     w_unused_hi;

    assign w_inject = (STALL_PERIOD != 0) && (int'(r_inj_cnt) == STALL_PERIOD - 1);
    assign w_stall  = !r_cal_done || (r_outstanding == OUTSTANDING_W'(MAX_OUTSTANDING)) || w_inject;
    assign w_accept = i_rst && i_wb_cyc && i_wb_stb && !w_stall;
    assign w_ack    = w_head_entry.valid;
    assign w_rdata  = r_mem[i_wb_addr];

    always_ff @(posedge i_controller_clk) begin
        if (!i_rst) begin
            r_cal_cnt  <= '0;
            r_cal_done <= 1'b0;
        end else if (!r_cal_done) begin
            r_cal_cnt <= r_cal_cnt + CAL_W'(1);
            if (r_cal_cnt == CAL_W'(CAL_CYCLES - 1)) begin
                r_cal_done <= 1'b1;
            end
        end
    end

    always_ff @(posedge i_controller_clk) begin
        if (!i_rst) begin
            r_inj_cnt <= '0;
        end else if (r_cal_done && STALL_PERIOD != 0) begin
            r_inj_cnt <= (int'(r_inj_cnt) == STALL_PERIOD - 1) ? '0 : r_inj_cnt + INJ_W'(1);
        end
    end

    // Dropping cyc abandons everything in flight, so the count resets with the flush.
    always_ff @(posedge i_controller_clk) begin
        if (!i_rst || !i_wb_cyc) begin
            r_outstanding <= '0;
        end else if (w_accept && !w_ack) begin
            r_outstanding <= r_outstanding + OUTSTANDING_W'(1);
        end else if (!w_accept && w_ack) begin
            r_outstanding <= r_outstanding - OUTSTANDING_W'(1);
        end
    end

    // RAM has no reset so its contents survive a controller reset.
    always_ff @(posedge i_controller_clk) begin
        if (w_accept && i_wb_we) begin
            for (int b = 0; b < SEL_BITS; b++) begin
                if (i_wb_sel[b]) begin
                    r_mem[i_wb_addr][b*8 +: 8] <= i_wb_data[b*8 +: 8];
                end
            end
        end
    end

    always_comb begin
        w_in_entry = '0;
        if (w_accept) begin
            w_in_entry.valid = 1'b1;
            w_in_entry.we    = i_wb_we;
            w_in_entry.aux   = RESP_AUX_MAX'(i_aux);
            if (!i_wb_we) begin
                w_in_entry.data = RESP_DATA_MAX'(w_rdata);
            end
        end
    end

    wb_resp_delay_line #(
        .DEPTH(RESP_LATENCY)
    ) u_delay (
        .i_controller_clk(i_controller_clk),
        .i_rst           (i_rst),
        .i_flush         (!i_wb_cyc),
        .i_entry         (w_in_entry),
        .o_head          (w_head_entry)
    );

    assign w_unused_hi   = ^{w_head_entry.we, w_head_entry.data >> DATA_BITS, w_head_entry.aux >> AUX_WIDTH};

    assign o_wb_stall    = w_stall;
    assign o_wb_ack      = w_head_entry.valid;
    assign o_wb_data     = w_head_entry.data[DATA_BITS-1:0];
    assign o_aux         = w_head_entry.aux[AUX_WIDTH-1:0];
    assign o_cal_done    = r_cal_done;
    assign o_outstanding = r_outstanding;
endmodule

// File: tb/tb_wb_ddr3_responder_model.sv
// Directed bench: default instance for protocol, ordering and cancellation;
// a second instance with periodic stall injection for throughput.
module tb_wb_ddr3_responder_model;
    logic       clk;
    logic       rst;
    logic       cyc, stb, we;
    logic [7:0] addr, wdat;
    logic [0:0] sel;
    logic [3:0] aux;
    logic       stall, ack, cal;
    logic [7:0] rdat;
    logic [3:0] raux;
    logic [4:0] outst;

    logic       b_cyc, b_stb, b_we;
    logic [7:0] b_addr, b_wdat;
    logic [0:0] b_sel;
    logic [3:0] b_aux;
    logic       b_stall, b_ack, b_cal;
    logic [7:0] b_rdat;
    logic [3:0] b_raux;
    logic [4:0] b_outst;

    int n_vec = 0;
    int n_mis = 0;
    int n_acc, n_ack, n_stl, cnt, peak, last_stl;
    int acc_off [6];
    int ack_off [6];
    logic [7:0] ack_dat [6];
    logic [3:0] ack_aux [6];
    logic stall_hist [20];
    logic [7:0] rd;
    int exp_acc_off [6] = '{0, 1, 2, 3, 7, 8};
    int exp_ack_off [6] = '{6, 7, 8, 9, 13, 14};

    wb_ddr3_responder_model dut (
        .i_controller_clk(clk), .i_rst(rst),
        .i_wb_cyc(cyc), .i_wb_stb(stb), .i_wb_we(we), .i_wb_addr(addr),
        .i_wb_data(wdat), .i_wb_sel(sel), .i_aux(aux),
        .o_wb_stall(stall), .o_wb_ack(ack), .o_wb_data(rdat), .o_aux(raux),
        .o_cal_done(cal), .o_outstanding(outst)
    );

    wb_ddr3_responder_model #(.MAX_OUTSTANDING(6), .STALL_PERIOD(5)) dut_inj (
        .i_controller_clk(clk), .i_rst(rst),
        .i_wb_cyc(b_cyc), .i_wb_stb(b_stb), .i_wb_we(b_we), .i_wb_addr(b_addr),
        .i_wb_data(b_wdat), .i_wb_sel(b_sel), .i_aux(b_aux),
        .o_wb_stall(b_stall), .o_wb_ack(b_ack), .o_wb_data(b_rdat), .o_aux(b_raux),
        .o_cal_done(b_cal), .o_outstanding(b_outst)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic w, input logic [7:0] a, input logic [7:0] d, input logic s, input logic [3:0] x);
        cyc = 1'b1; stb = 1'b1; we = w; addr = a; wdat = d; sel = s; aux = x;
    endtask

    task automatic xfer(input logic w, input logic [7:0] a, input logic [7:0] d, input logic s, output logic [7:0] r);
        int budget;
        drive(w, a, d, s, 4'h0);
        budget = 0;
        while (stall && budget < 200) begin tick(); budget++; end
        chk("xfer_accept_timeout", budget < 200, 1);
        tick();
        stb = 1'b0;
        budget = 0;
        while (!ack && budget < 20) begin tick(); budget++; end
        chk("xfer_ack_timeout", ack, 1);
        r = rdat;
        tick();
    endtask

    initial begin
        rst = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0; addr = '0; wdat = '0; sel = '0; aux = '0;
        b_cyc = 1'b0; b_stb = 1'b0; b_we = 1'b0; b_addr = '0; b_wdat = '0; b_sel = '0; b_aux = '0;
        tick(); tick();
        chk("rst_ack", ack, 0);
        chk("rst_data", rdat, 0);
        chk("rst_aux", raux, 0);
        chk("rst_cal", cal, 0);
        chk("rst_outst", outst, 0);
        chk("rst_stall", stall, 1);

        // Calibration window: 64 stalled cycles after release.
        rst = 1'b1;
        cnt = 0; n_stl = 0;
        while (!cal && cnt < 100) begin
            if (stall) n_stl++;
            cnt++;
            tick();
        end
        chk("cal_cycles", cnt, 64);
        chk("cal_stall_cycles", n_stl, 64);
        chk("cal_done_stall", stall, 0);
        cyc = 1'b1;

        // Write then read-after-write, back to back.
        drive(1'b1, 8'h9E, 8'h61, 1'b1, 4'h1); tick();
        drive(1'b0, 8'h9E, 8'h00, 1'b0, 4'h0);
        chk("raw_outst1", outst, 1);
        tick(); stb = 1'b0;
        chk("raw_outst2", outst, 2);
        tick(); tick(); tick();
        chk("raw_no_early_ack", ack, 0);
        tick();
        chk("wr_ack", ack, 1);
        chk("wr_ack_data", rdat, 0);
        chk("wr_ack_aux", raux, 1);
        tick();
        chk("rd_ack", ack, 1);
        chk("rd_ack_data", rdat, 8'h61);
        chk("rd_ack_aux", raux, 0);
        chk("rd_ack_outst", outst, 1);
        tick();
        chk("raw_done_ack", ack, 0);
        chk("raw_done_outst", outst, 0);

        // Six back-to-back reads against the outstanding limit.
        for (int i = 0; i < 6; i++) xfer(1'b1, 8'(8'h20 + i), 8'(8'hA0 + i), 1'b1, rd);
        drive(1'b0, 8'h20, 8'h00, 1'b0, 4'h0);
        n_acc = 0; n_ack = 0; peak = 0;
        for (int t = 0; t < 20; t++) begin
            stall_hist[t] = stall;
            if (ack) begin
                if (n_ack < 6) begin
                    ack_off[n_ack] = t; ack_dat[n_ack] = rdat; ack_aux[n_ack] = raux;
                end
                n_ack++;
            end
            if (stb && !stall) begin
                if (n_acc < 6) acc_off[n_acc] = t;
                n_acc++;
            end
            if (int'(outst) > peak) peak = int'(outst);
            tick();
            if (n_acc < 6) begin
                addr = 8'(8'h20 + n_acc); aux = 4'(n_acc); stb = 1'b1;
            end else begin
                stb = 1'b0;
            end
        end
        chk("b2b_accepts", n_acc, 6);
        chk("b2b_acks", n_ack, 6);
        chk("b2b_peak_outst", peak, 4);
        chk("b2b_stall_full", stall_hist[4], 1);
        chk("b2b_stall_at_ack", stall_hist[6], 1);
        chk("b2b_resume", stall_hist[7], 0);
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("b2b_acc_off%0d", i), acc_off[i], exp_acc_off[i]);
            chk($sformatf("b2b_ack_off%0d", i), ack_off[i], exp_ack_off[i]);
            chk($sformatf("b2b_ack_data%0d", i), ack_dat[i], 8'(8'hA0 + i));
            chk($sformatf("b2b_ack_aux%0d", i), ack_aux[i], 4'(i));
        end

        // Read sampled at accept is not disturbed by a following write.
        xfer(1'b1, 8'h10, 8'h33, 1'b1, rd);
        drive(1'b0, 8'h10, 8'h00, 1'b0, 4'h5); tick();
        drive(1'b1, 8'h10, 8'h44, 1'b1, 4'h6); tick();
        stb = 1'b0;
        tick(); tick(); tick(); tick();
        chk("war_rd_ack", ack, 1);
        chk("war_rd_data", rdat, 8'h33);
        chk("war_rd_aux", raux, 5);
        tick();
        chk("war_wr_ack", ack, 1);
        chk("war_wr_aux", raux, 6);
        tick();
        xfer(1'b0, 8'h10, 8'h00, 1'b0, rd);
        chk("war_readback", rd, 8'h44);

        // Cancellation with three requests in flight.
        drive(1'b1, 8'h30, 8'h5A, 1'b1, 4'h7); tick();
        drive(1'b0, 8'h20, 8'h00, 1'b0, 4'h8); tick();
        drive(1'b0, 8'h21, 8'h00, 1'b0, 4'h9); tick();
        stb = 1'b0; cyc = 1'b0;
        chk("cancel_pre_outst", outst, 3);
        tick();
        cyc = 1'b1;
        chk("cancel_outst", outst, 0);
        cnt = 0;
        for (int t = 0; t < 10; t++) begin
            if (ack) cnt++;
            tick();
        end
        chk("cancel_no_acks", cnt, 0);
        xfer(1'b0, 8'h30, 8'h00, 1'b0, rd);
        chk("cancel_write_kept", rd, 8'h5A);
        xfer(1'b1, 8'h30, 8'hFF, 1'b0, rd);
        xfer(1'b0, 8'h30, 8'h00, 1'b0, rd);
        chk("sel0_no_write", rd, 8'h5A);

        // Stall injection: one stalled cycle in five with stb held.
        b_cyc = 1'b1; b_stb = 1'b1; b_we = 1'b1; b_sel = 1'b1;
        n_acc = 0; n_stl = 0; n_ack = 0; last_stl = -1; cnt = 0;
        for (int t = 0; t < 50; t++) begin
            if (b_stall) begin
                n_stl++;
                if (last_stl >= 0 && t - last_stl != 5) cnt++;
                last_stl = t;
            end else begin
                n_acc++;
            end
            if (b_ack) n_ack++;
            tick();
        end
        b_stb = 1'b0;
        for (int t = 0; t < 12; t++) begin
            if (b_ack) n_ack++;
            tick();
        end
        chk("inj_accepts", n_acc, 40);
        chk("inj_stalls", n_stl, 10);
        chk("inj_bad_spacing", cnt, 0);
        chk("inj_acks", n_ack, 40);

        // Reset with requests in flight drops them; RAM survives.
        drive(1'b0, 8'h21, 8'h00, 1'b0, 4'h3); tick();
        drive(1'b0, 8'h22, 8'h00, 1'b0, 4'h4); tick();
        stb = 1'b0; rst = 1'b0;
        tick();
        rst = 1'b1;
        chk("mid_rst_ack", ack, 0);
        chk("mid_rst_outst", outst, 0);
        chk("mid_rst_cal", cal, 0);
        cnt = 0; n_ack = 0;
        while (!cal && cnt < 100) begin
            if (ack) n_ack++;
            cnt++;
            tick();
        end
        chk("mid_rst_recal", cnt, 64);
        chk("mid_rst_no_acks", n_ack, 0);
        xfer(1'b0, 8'h30, 8'h00, 1'b0, rd);
        chk("mid_rst_ram_kept", rd, 8'h5A);
        xfer(1'b0, 8'h21, 8'h00, 1'b0, rd);
        chk("mid_rst_ram_kept2", rd, 8'hA1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end
endmodule
